// File: rtl/conv33_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv33_seq_ctrl_if
//  Purpose  : Handshake/status bundle between the 3x3 convolution frame
//             sequencer and its neighbours (frame source, line buffer,
//             compute stage, output control).
//  Signals  : start, pix_valid, out_ready      -> into the sequencer
//             pix_ready, lb_wr_en, win_valid,
//             out_row, out_col, busy, done     <- out of the sequencer
//  Modports : master = environment side, slave = sequencer side
//  Revision : 1.0 - initial release
// ============================================================================
interface conv33_seq_ctrl_if #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic          start;
  logic          pix_valid;
  logic          pix_ready;
  logic          out_ready;
  logic          lb_wr_en;
  logic          win_valid;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          busy;
  logic          done;

  modport master (
    output start, pix_valid, out_ready,
    input  pix_ready, lb_wr_en, win_valid, out_row, out_col, busy, done
  );

  modport slave (
    input  start, pix_valid, out_ready,
    output pix_ready, lb_wr_en, win_valid, out_row, out_col, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/conv33_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : conv33_seq_ctrl
//  Purpose  : Frame-level sequencer for the 3x3 convolution datapath. Accepts
//             one feature map pixel by pixel, drives the line-buffer write
//             enable, flags every cycle with a complete 3x3 window (tagged with
//             its output coordinates), waits out the downstream pipeline after
//             the last pixel and then pulses done.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous reset, active high
//             bus  - conv33_seq_ctrl_if.slave (start, pix_valid, out_ready in;
//                    pix_ready, lb_wr_en, win_valid, out_row, out_col, busy,
//                    done out)
//  Revision : 1.0 - initial release
// ============================================================================
module conv33_seq_ctrl #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int PIPE_LAT = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  conv33_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

  localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_COL_TWO  = CW'(2);
  localparam logic [RW-1:0] C_ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] C_COL_ONE  = CW'(1);
  localparam logic [RW-1:0] C_ROW_ONE  = RW'(1);
  localparam logic [DW-1:0] C_DRN_ONE  = DW'(1);
  localparam logic [DW-1:0] C_DRN_LOAD = DW'(PIPE_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [DW-1:0] r_drain;
  logic          r_win_valid;
  logic [RW-1:0] r_out_row;
  logic [CW-1:0] r_out_col;
  logic          r_busy;
  logic          r_done;

  logic w_pix_ready;
  logic w_fire;
  logic w_win_hit;

  // Back-pressure from the output side directly gates pixel acceptance, so a
  // stalled downstream never receives a new window in the same cycle.
  assign w_pix_ready = (r_state == ST_LOAD) & bus.out_ready;
  assign w_fire      = w_pix_ready & bus.pix_valid;
  // Window completes when the incoming pixel is at least the third row and
  // third column (pre-increment counters).
  assign w_win_hit   = (r_row >= C_ROW_TWO) & (r_col >= C_COL_TWO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_drain     <= '0;
      r_win_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_win_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_LOAD;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_fire) begin
            if (w_win_hit) begin
              r_win_valid <= 1'b1;
              r_out_row   <= r_row - C_ROW_TWO;
              r_out_col   <= r_col - C_COL_TWO;
            end
            if (r_col == C_COL_LAST) begin
              r_col <= '0;
              if (r_row == C_ROW_LAST) begin
                r_row   <= '0;
                r_state <= ST_DRAIN;
                r_drain <= C_DRN_LOAD;
              end else begin
                r_row <= r_row + C_ROW_ONE;
              end
            end else begin
              r_col <= r_col + C_COL_ONE;
            end
          end
        end
        ST_DRAIN: begin
          // Counter runs PIPE_LAT..0, i.e. PIPE_LAT+1 cycles in this state.
          if (r_drain == '0) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain - C_DRN_ONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pix_ready = w_pix_ready;
  assign bus.lb_wr_en  = w_fire;
  assign bus.win_valid = r_win_valid;
  assign bus.out_row   = r_out_row;
  assign bus.out_col   = r_out_col;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv33_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv33_seq_ctrl
//  Purpose  : Self-checking bench for conv33_seq_ctrl. Two instances: 5x4 and
//             3x3 frames, both PIPE_LAT=2. A pixel-index model predicts every
//             output each cycle; literal tables pin window order, window
//             timing relative to fires, per-frame totals and done latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv33_seq_ctrl;
  localparam int PIPE_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic st [2];
  logic pv [2];
  logic orr [2];

  conv33_seq_ctrl_if #(.IMG_W(5), .IMG_H(4)) if5 ();
  conv33_seq_ctrl_if #(.IMG_W(3), .IMG_H(3)) if3 ();

  assign if5.start     = st[0];
  assign if5.pix_valid = pv[0];
  assign if5.out_ready = orr[0];
  assign if3.start     = st[1];
  assign if3.pix_valid = pv[1];
  assign if3.out_ready = orr[1];

  conv33_seq_ctrl #(.IMG_W(5), .IMG_H(4), .PIPE_LAT(PIPE_LAT)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (if5)
  );
  conv33_seq_ctrl #(.IMG_W(3), .IMG_H(3), .PIPE_LAT(PIPE_LAT)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  logic        a_pr [2], a_lb [2], a_wv [2], a_busy [2], a_done [2];
  logic [31:0] a_row [2], a_col [2];
  assign a_pr[0]   = if5.pix_ready;  assign a_pr[1]   = if3.pix_ready;
  assign a_lb[0]   = if5.lb_wr_en;   assign a_lb[1]   = if3.lb_wr_en;
  assign a_wv[0]   = if5.win_valid;  assign a_wv[1]   = if3.win_valid;
  assign a_busy[0] = if5.busy;       assign a_busy[1] = if3.busy;
  assign a_done[0] = if5.done;       assign a_done[1] = if3.done;
  assign a_row[0]  = 32'(if5.out_row); assign a_row[1] = 32'(if3.out_row);
  assign a_col[0]  = 32'(if5.out_col); assign a_col[1] = 32'(if3.out_col);

  int n_vec = 0;
  int n_err = 0;

  function automatic int wid(input int i); return (i == 0) ? 5 : 3; endfunction
  function automatic int hgt(input int i); return (i == 0) ? 4 : 3; endfunction

  // Hand-computed tables: fire count preceding each window, and its coords.
  function automatic int fire_tab(input int i, input int w);
    if (i == 1) return 9;
    case (w)
      0: return 13; 1: return 14; 2: return 15;
      3: return 18; 4: return 19; default: return 20;
    endcase
  endfunction
  function automatic int row_tab(input int i, input int w);
    if (i == 1) return 0;
    return (w < 3) ? 0 : 1;
  endfunction
  function automatic int col_tab(input int i, input int w);
    if (i == 1) return 0;
    case (w)
      0, 3: return 0;
      1, 4: return 1;
      default: return 2;
    endcase
  endfunction
  function automatic int tot_fires(input int i); return (i == 0) ? 20 : 9; endfunction
  function automatic int tot_wins(input int i);  return (i == 0) ? 6 : 1;  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %0d required %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 loading, 2 draining, 3 done; pixel index n.
  int   m_ph [2];
  int   m_n  [2];
  int   m_dr [2];
  logic m_wv [2];
  int   m_row [2];
  int   m_col [2];

  for (genvar g = 0; g < 2; g++) begin : g_model
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_ph[g]  <= 0;
        m_n[g]   <= 0;
        m_dr[g]  <= 0;
        m_wv[g]  <= 1'b0;
        m_row[g] <= 0;
        m_col[g] <= 0;
      end else begin
        m_wv[g] <= 1'b0;
        case (m_ph[g])
          0: if (st[g]) begin
               m_ph[g] <= 1;
               m_n[g]  <= 0;
             end
          1: if (orr[g] && pv[g]) begin
               if ((m_n[g] / wid(g)) >= 2 && (m_n[g] % wid(g)) >= 2) begin
                 m_wv[g]  <= 1'b1;
                 m_row[g] <= m_n[g] / wid(g) - 2;
                 m_col[g] <= m_n[g] % wid(g) - 2;
               end
               m_n[g] <= m_n[g] + 1;
               if (m_n[g] + 1 == wid(g) * hgt(g)) begin
                 m_ph[g] <= 2;
                 m_dr[g] <= PIPE_LAT;
               end
             end
          2: if (m_dr[g] == 0) m_ph[g] <= 3;
             else m_dr[g] <= m_dr[g] - 1;
          default: m_ph[g] <= 0;
        endcase
      end
    end
  end

  int f_cnt [2] = '{0, 0};
  int w_cnt [2] = '{0, 0};
  int last_f [2] = '{0, 0};
  int cyc = 0;

  always @(negedge clk) begin
    logic e_pr;
    for (int i = 0; i < 2; i++) begin
      e_pr = (m_ph[i] == 1) && orr[i];
      chk("pix_ready", i, 32'(a_pr[i]), 32'(e_pr));
      chk("lb_wr_en", i, 32'(a_lb[i]), 32'(e_pr && pv[i]));
      chk("busy", i, 32'(a_busy[i]), 32'(m_ph[i] == 1 || m_ph[i] == 2));
      chk("done", i, 32'(a_done[i]), 32'(m_ph[i] == 3));
      chk("win_valid", i, 32'(a_wv[i]), 32'(m_wv[i]));
      chk("out_row", i, a_row[i], m_row[i]);
      chk("out_col", i, a_col[i], m_col[i]);
      if (rst) begin
        f_cnt[i] = 0;
        w_cnt[i] = 0;
      end else begin
        if (a_wv[i]) begin
          if (w_cnt[i] < tot_wins(i)) begin
            chk("win_after_fire", i, f_cnt[i], fire_tab(i, w_cnt[i]));
            chk("win_row_table", i, a_row[i], row_tab(i, w_cnt[i]));
            chk("win_col_table", i, a_col[i], col_tab(i, w_cnt[i]));
          end else begin
            n_vec++;
            n_err++;
            $display("FAIL win_extra[%0d] got window %0d required at most %0d", i, w_cnt[i] + 1, tot_wins(i));
          end
          w_cnt[i]++;
        end
        if (a_lb[i]) begin
          f_cnt[i]++;
          last_f[i] = cyc;
        end
        if (a_done[i]) begin
          chk("frame_fires", i, f_cnt[i], tot_fires(i));
          chk("frame_windows", i, w_cnt[i], tot_wins(i));
          chk("done_delay", i, cyc - last_f[i], 4);
          f_cnt[i] = 0;
          w_cnt[i] = 0;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous, 1: out_ready toggles 1,0, 2: random pix_valid gaps
  task automatic run_frame(input int idx, input int mode, input int abort_at, input bit extra_start);
    bit finished;
    finished = 1'b0;
    st[idx] = 1'b1; pv[idx] = 1'b0; orr[idx] = 1'b1;
    tick();
    st[idx] = 1'b0;
    for (int k = 0; k < 400 && !finished; k++) begin
      pv[idx]  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      orr[idx] = (mode == 1) ? ((k % 2) == 0) : 1'b1;
      st[idx]  = extra_start && (k == 5);
      tick();
      if (abort_at > 0 && f_cnt[idx] == abort_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_pix_ready", idx, 32'(a_pr[idx]), 0);
        chk("rst_lb_wr_en", idx, 32'(a_lb[idx]), 0);
        chk("rst_win_valid", idx, 32'(a_wv[idx]), 0);
        chk("rst_out_row", idx, a_row[idx], 0);
        chk("rst_out_col", idx, a_col[idx], 0);
        chk("rst_busy", idx, 32'(a_busy[idx]), 0);
        chk("rst_done", idx, 32'(a_done[idx]), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        finished = 1'b1;
      end else if (m_ph[idx] == 3) begin
        st[idx] = extra_start;
        tick();
        st[idx] = 1'b0;
        finished = 1'b1;
      end
    end
    if (!finished) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_timeout[%0d] got no done required done within 400 cycles", idx);
    end
    st[idx] = 1'b0; pv[idx] = 1'b0; orr[idx] = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    st[0] = 1'b0; st[1] = 1'b0;
    pv[0] = 1'b1; pv[1] = 1'b0;
    orr[0] = 1'b1; orr[1] = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pix_ready", 0, 32'(a_pr[0]), 0);
    chk("reset_lb_wr_en", 0, 32'(a_lb[0]), 0);
    chk("reset_win_valid", 0, 32'(a_wv[0]), 0);
    chk("reset_busy", 0, 32'(a_busy[0]), 0);
    chk("reset_done", 0, 32'(a_done[0]), 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_ignores_pix", 0, 32'(a_lb[0]), 0);
    pv[0] = 1'b0;

    run_frame(0, 0, 0, 1'b0);
    run_frame(0, 1, 0, 1'b0);
    run_frame(0, 2, 0, 1'b0);
    run_frame(0, 0, 0, 1'b1);
    chk("restart_ignored_busy", 0, 32'(a_busy[0]), 0);
    run_frame(0, 0, 9, 1'b0);
    run_frame(0, 0, 0, 1'b0);
    run_frame(1, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv33_seq_ctrl.md
Name: conv33_seq_ctrl

Overview:
Frame-level sequencer for the 3x3 convolution datapath. It accepts one input feature map pixel by pixel and drives the line-buffer write enable. It flags each cycle in which a full 3x3 window is available, so the compute stage can fire, and tags each window with its output coordinates. After the last pixel it waits out the compute/output pipeline, then pulses done. It sits between the frame source and the line buffer, compute stage and output control.

Parameters:
IMG_W, 28, input feature map width in pixels (>=3)
IMG_H, 28, input feature map height in pixels (>=3)
PIPE_LAT, 2, cycles from win_valid to the last output_valid of the downstream pipeline
CW, $clog2(IMG_W), column counter width (derived)
RW, $clog2(IMG_H), row counter width (derived)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle request to begin a frame; honoured only in IDLE
pix_valid  input  1  source has a pixel this cycle
pix_ready  output  1  block accepts a pixel this cycle
out_ready  input  1  downstream can absorb a window; low = stall
lb_wr_en  output  1  line-buffer write/shift enable = pix_valid & pix_ready (combinational "fire")
win_valid  output  1  registered; 3x3 window complete, compute may fire
out_row  output  RW  registered; output row of current window (0..IMG_H-3)
out_col  output  CW  registered; output column of current window (0..IMG_W-3)
busy  output  1  high in LOAD and DRAIN
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, rst=1): state=IDLE; row, col and drain counters=0. Outputs: pix_ready=0, lb_wr_en=0, win_valid=0, out_row=0, out_col=0, busy=0, done=0. Reset mid-frame abandons the frame with no done pulse.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - pix_ready=0, busy=0.
  - start=1 -> LOAD; row and col clear to 0.
- LOAD:
  - busy=1; pix_ready=out_ready (combinational).
  - fire = pix_valid & pix_ready. No fire means all counters hold.
  - On fire, col increments. At col==IMG_W-1, col wraps to 0 and row increments.
  - On fire with row>=2 and col>=2: next cycle win_valid=1, out_row=row-2, out_col=col-2. Otherwise next cycle win_valid=0, and out_row/out_col hold their values.
  - Fire on the last pixel (row==IMG_H-1, col==IMG_W-1) -> DRAIN, drain counter loaded with PIPE_LAT.
- DRAIN:
  - busy=1, pix_ready=0.
  - Counter decrements each cycle. At 0 -> DONE. DRAIN therefore lasts PIPE_LAT+1 cycles.
- DONE:
  - done=1 for exactly one cycle, busy=0 -> IDLE.
  - A start arriving while done=1 is ignored.
- Window count per frame = (IMG_W-2)*(IMG_H-2). Windows are issued in raster order.
- start while busy or in DONE is ignored; no restart and no error flag.
- Stall: out_ready low blocks fire in the same cycle. The win_valid registered from the previous fire still asserts once, and the downstream must absorb it.
- pix_valid high outside LOAD is ignored; lb_wr_en is never high outside LOAD.
- Counter arithmetic is unsigned. The row>=2/col>=2 compare uses pre-increment values.

Test Plan:
- IMG_W=5, IMG_H=4, PIPE_LAT=2. Start pulse, then pix_valid=1 and out_ready=1 continuously.
  - Required: 20 lb_wr_en cycles and 6 win_valid pulses.
  - (out_row,out_col) sequence: (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - First win_valid the cycle after the 13th fire.
  - done occurs 4 cycles after the last fire; busy falls with done.
- Same frame, out_ready toggled 1,0 every cycle -> still exactly 6 windows in the same order. No fire in any out_ready=0 cycle. Frame length doubles.
- pix_valid gaps (random 50%) -> counts and coordinates identical to the first scenario; win_valid is never asserted without a preceding fire.
- start pulsed again mid-LOAD and while done=1 -> ignored. Counters are unaffected and the frame completes normally with one done.
- rst asserted after the 9th fire -> all outputs 0 immediately (asynchronous). A new start then gives a clean frame with 6 windows starting at (0,0).
- IMG_W=3, IMG_H=3 -> a single window (0,0) after the 9th fire. done occurs PIPE_LAT+2 cycles after that fire.
